// File: rtl/ofm_drain_pkg.sv
// Shared types and sizing for the OFM drain serializer.
// Default geometry matches the CONV_256PE array; the top recomputes sizes from its own parameters.
package ofm_drain_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_OF_PE_DEF = 256;
    localparam int DATA_W_DEF    = 8;
    localparam int OUT_LANES_DEF = 16;
    localparam int NUM_TILES_DEF = 4;

    localparam int BEATS  = NUM_OF_PE_DEF / OUT_LANES_DEF;
    localparam int BEAT_W = cnt_w(BEATS);
    localparam int TILE_W = cnt_w(NUM_TILES_DEF);

endpackage

// File: rtl/ofm_drain_serializer_beat_select.sv
// Beat payload mux: picks OUT_LANES consecutive lanes of the holding buffer for the current beat.
// Output is forced to zero when no beat is being presented.
module ofm_beat_select
    import ofm_drain_pkg::*;
#(
    parameter int NUM_OF_PE = NUM_OF_PE_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OUT_LANES = OUT_LANES_DEF,
    parameter int BEAT_W    = 4
) (
    input  logic [NUM_OF_PE*DATA_W-1:0] i_buf,
    input  logic [BEAT_W-1:0]           i_beat,
    input  logic                        i_en,
    output logic [OUT_LANES*DATA_W-1:0] o_data
);

    for (genvar l = 0; l < OUT_LANES; l++) begin : g_lane
        logic [DATA_W-1:0] w_lane;
        assign w_lane = i_buf[(int'(i_beat) * OUT_LANES + l) * DATA_W +: DATA_W];
        assign o_data[l*DATA_W +: DATA_W] = i_en ? w_lane : '0;
    end

endmodule

// File: rtl/ofm_drain_serializer.sv
// Captures the PE array OFM vector after a finish pulse and streams it out as valid/ready beats,
// tracking the tile index within a frame and flagging finish pulses that arrive while busy.
module ofm_drain_serializer
    import ofm_drain_pkg::*;
#(
    parameter int NUM_OF_PE = NUM_OF_PE_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OUT_LANES = OUT_LANES_DEF,
    parameter int NUM_TILES = NUM_TILES_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_OF_PE*DATA_W-1:0]          ofm_i,
    input  logic                                 pe_finish_i,
    input  logic                                 start_i,
    output logic [OUT_LANES*DATA_W-1:0]          out_data_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic                                 out_last_o,
    output logic                                 out_frame_last_o,
    output logic [cnt_w(NUM_TILES)-1:0]          tile_idx_o,
    output logic                                 busy_o,
    output logic                                 overrun_o,
    output logic                                 frame_done_o
);

    localparam int L_BEATS  = NUM_OF_PE / OUT_LANES;
    localparam int L_BEAT_W = cnt_w(L_BEATS);
    localparam int L_TILE_W = cnt_w(NUM_TILES);

    localparam logic [L_BEAT_W-1:0] LAST_BEAT = L_BEAT_W'(L_BEATS - 1);
    localparam logic [L_TILE_W-1:0] LAST_TILE = L_TILE_W'(NUM_TILES - 1);

    state_e                      r_state;
    state_e                      w_next;
    logic [NUM_OF_PE*DATA_W-1:0] r_buf;
    logic [L_BEAT_W-1:0]         r_beat;
    logic [L_TILE_W-1:0]         r_tile;
    logic                        r_overrun;
    logic                        r_frame_done;

    logic w_valid;
    logic w_last;
    logic w_frame_last;
    logic w_hs;
    logic w_last_hs;
    logic w_start;
    logic w_drop;

    assign w_valid      = (r_state == DRAIN);
    assign w_last       = w_valid && (r_beat == LAST_BEAT);
    assign w_frame_last = w_last && (r_tile == LAST_TILE);
    assign w_hs         = w_valid && out_ready_i;
    assign w_last_hs    = w_hs && w_last;
    assign w_start      = (r_state == IDLE) && start_i;
    // A finish is only absorbed in IDLE or on the edge that retires the final beat.
    assign w_drop       = pe_finish_i &&
                          ((r_state == CAPTURE) || ((r_state == DRAIN) && !w_last_hs));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (pe_finish_i) w_next = CAPTURE;
            CAPTURE: w_next = DRAIN;
            DRAIN:   if (w_last_hs) w_next = pe_finish_i ? CAPTURE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf        <= '0;
            r_beat       <= '0;
            r_tile       <= '0;
            r_overrun    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (r_state == CAPTURE) begin
                r_buf  <= ofm_i;
                r_beat <= '0;
            end else if (w_hs) begin
                r_beat <= w_last ? '0 : r_beat + 1'b1;
            end

            if (w_start) begin
                r_tile <= '0;
            end else if (w_last_hs) begin
                r_tile <= (r_tile == LAST_TILE) ? '0 : r_tile + 1'b1;
            end

            if (w_start) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end

            r_frame_done <= w_last_hs && w_frame_last;
        end
    end

    ofm_beat_select #(
        .NUM_OF_PE (NUM_OF_PE),
        .DATA_W    (DATA_W),
        .OUT_LANES (OUT_LANES),
        .BEAT_W    (L_BEAT_W)
    ) u_beat_select (
        .i_buf  (r_buf),
        .i_beat (r_beat),
        .i_en   (w_valid),
        .o_data (out_data_o)
    );

    assign out_valid_o      = w_valid;
    assign out_last_o       = w_last;
    assign out_frame_last_o = w_frame_last;
    assign tile_idx_o       = r_tile;
    assign busy_o           = (r_state != IDLE);
    assign overrun_o        = r_overrun;
    assign frame_done_o     = r_frame_done;

endmodule

// File: doc/ofm_drain_serializer.md
# ofm_drain_serializer

Output-side drain for the CONV_256PE array. Captures the full NUM_OF_PE-lane OFM vector one cycle after the array's finish pulse, then streams it out as OUT_LANES-byte beats over a valid/ready interface toward the OFM buffer or writer. Tracks the tile index across a frame and flags finish pulses it cannot absorb. It replaces the bench-side OFM dump with synthesizable logic.

## Interface
- NUM_OF_PE, 256, PE lanes in the OFM vector
- DATA_W, 8, bits per PE output
- OUT_LANES, 16, PE outputs per output beat; must divide NUM_OF_PE
- NUM_TILES, 4, tiles per frame (32x32 OFM / 256 PEs)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ofm_i  in  NUM_OF_PE*DATA_W  PE array OFM; lane k at [k*DATA_W +: DATA_W]
- pe_finish_i  in  1  one-cycle finish pulse, same pulse driven to the array's PE_finish
- start_i  in  1  frame start; clears tile index and overrun in IDLE
- out_data_o  out  OUT_LANES*DATA_W  beat payload
- out_valid_o  out  1  beat valid
- out_ready_i  in  1  downstream accept
- out_last_o  out  1  last beat of the current tile
- out_frame_last_o  out  1  last beat of the last tile in the frame
- tile_idx_o  out  clog2(NUM_TILES)  tile currently held or draining
- busy_o  out  1  state is not IDLE
- overrun_o  out  1  sticky: finish pulse dropped
- frame_done_o  out  1  one-cycle pulse after the frame's final beat is accepted

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE: pe_finish_i sampled high -> CAPTURE. start_i sampled high -> tile_idx=0 and overrun=0. If both are high on the same edge, both actions apply.
- CAPTURE: lasts exactly one cycle. Registers ofm_i into the holding buffer, clears beat_cnt, then moves to DRAIN.
- DRAIN: out_valid_o=1. out_data_o = buffer lanes beat_cnt*OUT_LANES .. +OUT_LANES-1, with the lowest lane in the low byte.
- Each handshake (valid & ready) increments beat_cnt.
- out_last_o = (beat_cnt == BEATS-1), where BEATS = NUM_OF_PE/OUT_LANES (16 by default).
- out_frame_last_o = out_last_o & (tile_idx == NUM_TILES-1).
- Last-beat handshake:
  - tile_idx increments and wraps NUM_TILES-1 -> 0.
  - If out_frame_last_o was set, frame_done_o pulses on the next cycle.
  - If pe_finish_i is high on the same edge -> CAPTURE; otherwise -> IDLE.
- pe_finish_i high in CAPTURE, or in DRAIN without a last-beat handshake: the event is dropped, overrun_o is set, and the current drain is unaffected.
- start_i outside IDLE is ignored.
- beat_cnt width: clog2(BEATS). It never wraps mid-tile.

## Timing
- Reset values: out_valid_o=0, out_last_o=0, out_frame_last_o=0, frame_done_o=0, busy_o=0, overrun_o=0, tile_idx_o=0, out_data_o=0. State is IDLE.
- Latency: pe_finish_i sampled at edge E0, ofm_i captured at E1, first beat valid after E1. That is 2 cycles from finish to valid.
- Throughput: 1 beat/cycle with out_ready_i held high. A tile drains in 16 cycles, under the 28-cycle finish spacing of the PE schedule.
- out_data_o, out_last_o and out_frame_last_o hold stable while out_valid_o=1 and out_ready_i=0.
- out_valid_o never drops without a handshake.
- ofm_i must be stable through E1 only. Later changes to ofm_i do not affect the buffer.
- reset_n low mid-drain: immediate return to IDLE and out_valid_o=0. The partial tile is discarded.

## Structure
- Package ofm_drain_pkg holds:
  - state enum {IDLE, CAPTURE, DRAIN}
  - localparams BEATS, BEAT_W = clog2(BEATS), TILE_W = clog2(NUM_TILES)
- Sub-module ofm_beat_select: combinational mux from buffer and beat_cnt to out_data_o.
- The FSM, counters and buffer stay in the top module.

## Test plan
- Single tile: ofm_i lane k = k[7:0], finish pulse, ready high -> 16 beats. Beat 0 = 0x0F0E..0100, beat 15 low byte 0xF0. out_last_o only on beat 15. Valid 2 cycles after finish.
- Backpressure: ready toggles 1,0,0,1 -> no beat lost or duplicated, data stable during stalls, 16 handshakes total.
- Full frame: 4 finishes spaced 28 cycles -> tile_idx 0,1,2,3,0. out_frame_last_o on the 64th beat. frame_done_o one cycle later. overrun_o stays 0.
- Back-to-back: finish on the same edge as the last-beat handshake -> CAPTURE next cycle, no overrun. Finish at beat 5 -> overrun_o=1 and the current tile completes intact.
- Reset mid-drain at beat 7 -> out_valid_o=0 immediately, tile_idx_o=0. The next finish drains a full 16 beats.
- start_i with overrun set, in IDLE -> overrun_o=0 and tile_idx_o=0. The same start_i during DRAIN has no effect.
